// File: rtl/s2c_req_arb_if.sv
// Driver-side and upstream-side signal bundle for the scenario request arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface s2c_req_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [NUM_REQ-1:0] rsp_valid_o;
  logic [DATA_W-1:0]  rsp_data_o;
  logic               rsp_eod_o;
  logic               up_req_o;
  logic [IDW-1:0]     up_id_o;
  logic               up_ack_i;
  logic               up_rsp_valid_i;
  logic [DATA_W-1:0]  up_rsp_data_i;
  logic               up_rsp_eod_i;
  logic [NUM_REQ-1:0] done_o;
  logic               all_done_o;
  logic               busy_o;
  logic               timeout_err_o;

  modport slave (
    input  req_i, up_ack_i, up_rsp_valid_i, up_rsp_data_i, up_rsp_eod_i,
    output gnt_o, rsp_valid_o, rsp_data_o, rsp_eod_o, up_req_o, up_id_o,
           done_o, all_done_o, busy_o, timeout_err_o
  );

  modport master (
    output req_i, up_ack_i, up_rsp_valid_i, up_rsp_data_i, up_rsp_eod_i,
    input  gnt_o, rsp_valid_o, rsp_data_o, rsp_eod_o, up_req_o, up_id_o,
           done_o, all_done_o, busy_o, timeout_err_o
  );
endinterface

// File: rtl/s2c_req_arb.sv
// Round-robin arbiter sharing one scenario-data request channel among NUM_REQ drivers.
// Define S2C_ARB_TIMEOUT_EN to add a response timeout that forces an EOD response.
//
// state    | meaning
// IDLE     | pick next eligible driver (req & ~done) from the rotating pointer
// ISSUE    | hold up_req/up_id until upstream acks; pulse gnt on the ack cycle
// WAIT_RSP | wait for the upstream response strobe (or timeout when enabled)
// RESP     | one-cycle response pulse to the winner; update done and pointer
module s2c_req_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input logic          clk,
  input logic          rst,
  s2c_req_arb_if.slave bus
);
  localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int PW  = IDW + 1;

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("s2c_req_arb: NUM_REQ must be in 2..16");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("s2c_req_arb: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;

  state_t             state, state_nxt;
  logic [IDW-1:0]     ptr, ptr_nxt;
  logic [IDW-1:0]     idx, idx_nxt;
  logic [IDW-1:0]     win;
  logic               win_vld;
  logic [PW-1:0]      pos;
  logic [NUM_REQ-1:0] done, done_nxt;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] idx_oh;
  logic [DATA_W-1:0]  data_q, data_nxt;
  logic               eod_q, eod_nxt;

`ifdef S2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt, cnt_nxt;
  logic          to_err, to_err_nxt;
`endif

  assign eligible = bus.req_i & ~done;

  // Search upward from the pointer with wrap; first eligible driver wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    pos     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + PW'(i);
      if (pos >= PW'(NUM_REQ)) pos = pos - PW'(NUM_REQ);
      if (!win_vld && eligible[pos[IDW-1:0]]) begin
        win_vld = 1'b1;
        win     = pos[IDW-1:0];
      end
    end
  end

  always_comb begin
    idx_oh      = '0;
    idx_oh[idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    done_nxt  = done;
    data_nxt  = data_q;
    eod_nxt   = eod_q;
`ifdef S2C_ARB_TIMEOUT_EN
    cnt_nxt    = cnt;
    to_err_nxt = to_err;
`endif
    case (state)
      IDLE: begin
        if (win_vld) begin
          idx_nxt   = win;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.up_ack_i) begin
          state_nxt = WAIT_RSP;
`ifdef S2C_ARB_TIMEOUT_EN
          cnt_nxt = '0;
`endif
        end
      end
      WAIT_RSP: begin
        // A real response beats expiry when both land in the same cycle.
        if (bus.up_rsp_valid_i) begin
          data_nxt  = bus.up_rsp_data_i;
          eod_nxt   = bus.up_rsp_eod_i;
          state_nxt = RESP;
        end
`ifdef S2C_ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          data_nxt   = '0;
          eod_nxt    = 1'b1;
          to_err_nxt = 1'b1;
          state_nxt  = RESP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      RESP: begin
        if (eod_q) done_nxt = done | idx_oh;
        ptr_nxt   = (idx == IDW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      idx    <= '0;
      done   <= '0;
      data_q <= '0;
      eod_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      idx    <= idx_nxt;
      done   <= done_nxt;
      data_q <= data_nxt;
      eod_q  <= eod_nxt;
    end
  end

`ifdef S2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      to_err <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      to_err <= to_err_nxt;
    end
  end

  assign bus.timeout_err_o = to_err;
`else
  assign bus.timeout_err_o = 1'b0;
`endif

  assign bus.gnt_o       = (state == ISSUE && bus.up_ack_i) ? idx_oh : '0;
  assign bus.rsp_valid_o = (state == RESP) ? idx_oh : '0;
  assign bus.rsp_data_o  = (state == RESP) ? data_q : '0;
  assign bus.rsp_eod_o   = (state == RESP) ? eod_q : 1'b0;
  assign bus.up_req_o    = (state == ISSUE);
  assign bus.up_id_o     = (state == ISSUE) ? idx : '0;
  assign bus.done_o      = done;
  assign bus.all_done_o  = &done;
  assign bus.busy_o      = (state != IDLE);
endmodule

// File: tb/tb_s2c_req_arb.sv
// Directed bench for s2c_req_arb: transaction table plus hand-built stall, timeout and reset sequences.
// Timeout sequences compile only when S2C_ARB_TIMEOUT_EN is defined.
module tb_s2c_req_arb;
  logic clk = 1'b1;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  s2c_req_arb_if #(.NUM_REQ(4), .DATA_W(32)) bus ();

  s2c_req_arb #(.NUM_REQ(4), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  req;
    int          ack_dly;
    int          rsp_dly;
    logic [31:0] data;
    logic        eod;
    int          exp_id;
    logic [3:0]  exp_done;
    logic        exp_all;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req_i          = '0;
    bus.up_ack_i       = 1'b0;
    bus.up_rsp_valid_i = 1'b0;
    bus.up_rsp_data_i  = '0;
    bus.up_rsp_eod_i   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full transaction; junk response strobes are driven while in ISSUE and must be ignored.
  task automatic do_txn(input string tag, input logic [3:0] req, input int ack_dly,
                        input int rsp_dly, input logic [31:0] data, input logic eod,
                        input int exp_id, input logic wd, input logic [3:0] exp_done,
                        input logic exp_all);
    logic [3:0] oh;
    logic [3:0] pre_done;
    oh       = 4'b0001 << exp_id;
    pre_done = eod ? (exp_done & ~oh) : exp_done;
    bus.req_i = req;
    @(negedge clk);
    if (wd) bus.req_i = '0;
    for (int c = 0; c < ack_dly; c++) begin
      bus.up_rsp_valid_i = 1'b1;
      bus.up_rsp_data_i  = 32'hDEAD_BEEF;
      bus.up_rsp_eod_i   = 1'b1;
      #1;
      chk($sformatf("%s stall up_req", tag), 32'(bus.up_req_o), 32'd1);
      chk($sformatf("%s stall up_id", tag), 32'(bus.up_id_o), 32'(exp_id));
      chk($sformatf("%s stall gnt", tag), 32'(bus.gnt_o), 32'd0);
      @(negedge clk);
    end
    bus.up_ack_i       = 1'b1;
    bus.up_rsp_valid_i = 1'b1;
    bus.up_rsp_data_i  = 32'hBAD0_0ACC;
    bus.up_rsp_eod_i   = 1'b1;
    #1;
    chk($sformatf("%s up_req", tag), 32'(bus.up_req_o), 32'd1);
    chk($sformatf("%s up_id", tag), 32'(bus.up_id_o), 32'(exp_id));
    chk($sformatf("%s gnt", tag), 32'(bus.gnt_o), 32'(oh));
    @(negedge clk);
    bus.up_ack_i       = 1'b0;
    bus.up_rsp_valid_i = 1'b0;
    bus.up_rsp_data_i  = '0;
    bus.up_rsp_eod_i   = 1'b0;
    for (int c = 1; c < rsp_dly; c++) begin
      #1;
      chk($sformatf("%s wait rsp_valid", tag), 32'(bus.rsp_valid_o), 32'd0);
      chk($sformatf("%s wait busy", tag), 32'(bus.busy_o), 32'd1);
      @(negedge clk);
    end
    bus.up_rsp_valid_i = 1'b1;
    bus.up_rsp_data_i  = data;
    bus.up_rsp_eod_i   = eod;
    #1;
    chk($sformatf("%s early rsp_valid", tag), 32'(bus.rsp_valid_o), 32'd0);
    @(negedge clk);
    bus.up_rsp_valid_i = 1'b0;
    bus.up_rsp_data_i  = '0;
    bus.up_rsp_eod_i   = 1'b0;
    #1;
    chk($sformatf("%s rsp_valid", tag), 32'(bus.rsp_valid_o), 32'(oh));
    chk($sformatf("%s rsp_data", tag), bus.rsp_data_o, data);
    chk($sformatf("%s rsp_eod", tag), 32'(bus.rsp_eod_o), 32'(eod));
    chk($sformatf("%s done in resp", tag), 32'(bus.done_o), 32'(pre_done));
    @(negedge clk);
    #1;
    chk($sformatf("%s done", tag), 32'(bus.done_o), 32'(exp_done));
    chk($sformatf("%s all_done", tag), 32'(bus.all_done_o), 32'(exp_all));
    chk($sformatf("%s idle rsp_valid", tag), 32'(bus.rsp_valid_o), 32'd0);
    chk($sformatf("%s idle rsp_data", tag), bus.rsp_data_o, 32'd0);
    chk($sformatf("%s idle rsp_eod", tag), 32'(bus.rsp_eod_o), 32'd0);
    bus.req_i = '0;
  endtask

  // Request, immediate ack, then return at the first WAIT_RSP negedge with req dropped.
  task automatic start_wait(input string tag, input logic [3:0] req, input int exp_id);
    bus.req_i = req;
    @(negedge clk);
    bus.req_i    = '0;
    bus.up_ack_i = 1'b1;
    #1;
    chk($sformatf("%s gnt", tag), 32'(bus.gnt_o), 32'(4'b0001 << exp_id));
    @(negedge clk);
    bus.up_ack_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 0, 1, 32'h1000_0000, 1'b0, 0, 4'b0000, 1'b0};
    vecs[1]  = '{4'b1111, 0, 1, 32'h1000_0001, 1'b0, 1, 4'b0000, 1'b0};
    vecs[2]  = '{4'b1111, 1, 2, 32'h1000_0002, 1'b0, 2, 4'b0000, 1'b0};
    vecs[3]  = '{4'b1111, 0, 1, 32'h1000_0003, 1'b0, 3, 4'b0000, 1'b0};
    vecs[4]  = '{4'b1111, 2, 1, 32'h1000_0004, 1'b0, 0, 4'b0000, 1'b0};
    vecs[5]  = '{4'b0100, 0, 1, 32'hE0D0_0002, 1'b1, 2, 4'b0100, 1'b0};
    vecs[6]  = '{4'b1111, 0, 1, 32'h2000_0003, 1'b0, 3, 4'b0100, 1'b0};
    vecs[7]  = '{4'b0101, 0, 1, 32'hE0D0_0000, 1'b1, 0, 4'b0101, 1'b0};
    vecs[8]  = '{4'b1111, 1, 1, 32'hE0D0_0001, 1'b1, 1, 4'b0111, 1'b0};
    vecs[9]  = '{4'b1111, 0, 3, 32'h3000_0003, 1'b0, 3, 4'b0111, 1'b0};
    vecs[10] = '{4'b1111, 0, 1, 32'hE0D0_0003, 1'b1, 3, 4'b1111, 1'b1};

    clear_inputs();
    rst = 1'b1;
    #20;
    chk("rst gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst rsp_data", bus.rsp_data_o, 32'd0);
    chk("rst rsp_eod", 32'(bus.rsp_eod_o), 32'd0);
    chk("rst up_req", 32'(bus.up_req_o), 32'd0);
    chk("rst up_id", 32'(bus.up_id_o), 32'd0);
    chk("rst done", 32'(bus.done_o), 32'd0);
    chk("rst all_done", 32'(bus.all_done_o), 32'd0);
    chk("rst busy", 32'(bus.busy_o), 32'd0);
    chk("rst timeout_err", 32'(bus.timeout_err_o), 32'd0);
    #5 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle up_req", 32'(bus.up_req_o), 32'd0);
      chk("idle busy", 32'(bus.busy_o), 32'd0);
    end

    do_txn("single", 4'b0010, 0, 1, 32'hA5A5_0001, 1'b0, 1, 1'b0, 4'b0000, 1'b0);

    do_reset();
    for (int v = 0; v < 11; v++) begin
      do_txn($sformatf("vec%0d", v), vecs[v].req, vecs[v].ack_dly, vecs[v].rsp_dly,
             vecs[v].data, vecs[v].eod, vecs[v].exp_id, 1'b0, vecs[v].exp_done,
             vecs[v].exp_all);
    end
    bus.req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("alldone busy", 32'(bus.busy_o), 32'd0);
      chk("alldone up_req", 32'(bus.up_req_o), 32'd0);
      chk("alldone flag", 32'(bus.all_done_o), 32'd1);
    end
    bus.req_i = '0;

    do_reset();
    do_txn("withdraw", 4'b0001, 5, 7, 32'h7777_0005, 1'b0, 0, 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("withdraw after busy", 32'(bus.busy_o), 32'd0);
      chk("withdraw after gnt", 32'(bus.gnt_o), 32'd0);
      chk("withdraw after rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    end

    do_reset();
`ifdef S2C_ARB_TIMEOUT_EN
    start_wait("same", 4'b0100, 2);
    for (int n = 1; n <= 16; n++) begin
      if (n == 16) begin
        bus.up_rsp_valid_i = 1'b1;
        bus.up_rsp_data_i  = 32'h5A5A_0016;
      end
      #1;
      chk("same wait rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("same wait busy", 32'(bus.busy_o), 32'd1);
      @(negedge clk);
    end
    bus.up_rsp_valid_i = 1'b0;
    bus.up_rsp_data_i  = '0;
    #1;
    chk("same rsp_valid", 32'(bus.rsp_valid_o), 32'b0100);
    chk("same rsp_data", bus.rsp_data_o, 32'h5A5A_0016);
    chk("same rsp_eod", 32'(bus.rsp_eod_o), 32'd0);
    @(negedge clk);
    #1;
    chk("same timeout_err", 32'(bus.timeout_err_o), 32'd0);
    chk("same done", 32'(bus.done_o), 32'd0);

    start_wait("to", 4'b0010, 1);
    for (int n = 1; n <= 16; n++) begin
      #1;
      chk("to wait rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("to rsp_valid", 32'(bus.rsp_valid_o), 32'b0010);
    chk("to rsp_data", bus.rsp_data_o, 32'd0);
    chk("to rsp_eod", 32'(bus.rsp_eod_o), 32'd1);
    @(negedge clk);
    #1;
    chk("to timeout_err", 32'(bus.timeout_err_o), 32'd1);
    chk("to done", 32'(bus.done_o), 32'b0010);
    repeat (3) @(negedge clk);
    #1;
    chk("to timeout_err sticky", 32'(bus.timeout_err_o), 32'd1);

    start_wait("rstw", 4'b0001, 0);
    repeat (5) @(negedge clk);
`else
    start_wait("nto", 4'b0010, 1);
    for (int n = 0; n < 20; n++) begin
      #1;
      chk("nto rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("nto busy", 32'(bus.busy_o), 32'd1);
      @(negedge clk);
    end
    #1;
    chk("nto timeout_err", 32'(bus.timeout_err_o), 32'd0);
    @(negedge clk);
`endif
    rst                = 1'b1;
    bus.up_rsp_valid_i = 1'b1;
    bus.up_rsp_data_i  = 32'hFFFF_0BAD;
    bus.up_rsp_eod_i   = 1'b1;
    #1;
    chk("midrst busy", 32'(bus.busy_o), 32'd0);
    chk("midrst up_req", 32'(bus.up_req_o), 32'd0);
    chk("midrst rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("midrst rsp_data", bus.rsp_data_o, 32'd0);
    chk("midrst done", 32'(bus.done_o), 32'd0);
    chk("midrst all_done", 32'(bus.all_done_o), 32'd0);
    chk("midrst timeout_err", 32'(bus.timeout_err_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("postrst rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      chk("postrst busy", 32'(bus.busy_o), 32'd0);
      chk("postrst done", 32'(bus.done_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/s2c_req_arb.md
Name: s2c_req_arb

Overview:
- Round-robin arbiter that shares one scenario-data request channel between NUM_REQ drivers.
- Forwards one request at a time upstream to the scenario side and routes the response back to the winning driver.
- Tracks end-of-data (EOD) per driver.
- Sits between the drivers and the scenario request interface. Exposes a global all-done flag that the top-level end check polls.

Parameters:
NUM_REQ, 4, number of requesting drivers (2..16)
DATA_W, 32, width of scenario data word
TIMEOUT, 256, response timeout in cycles (used only with S2C_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, single clock domain
rst  in  1  reset, asynchronous, active-high
req_i  in  NUM_REQ  per-driver request level
gnt_o  out  NUM_REQ  one-hot, one-cycle pulse when the driver's request is accepted upstream
rsp_valid_o  out  NUM_REQ  one-hot, one-cycle pulse with response for that driver
rsp_data_o  out  DATA_W  response data, shared, valid with rsp_valid_o
rsp_eod_o  out  1  response is EOD, valid with rsp_valid_o
up_req_o  out  1  upstream request
up_id_o  out  IDW  requesting driver index; IDW = max(1, clog2(NUM_REQ))
up_ack_i  in  1  upstream accepts request
up_rsp_valid_i  in  1  upstream response strobe
up_rsp_data_i  in  DATA_W  upstream response data
up_rsp_eod_i  in  1  upstream response EOD flag
done_o  out  NUM_REQ  sticky per-driver EOD received
all_done_o  out  1  AND of done_o
busy_o  out  1  FSM not in IDLE
timeout_err_o  out  1  sticky timeout flag (tied 0 without macro)

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Priority pointer 0.
  - done cleared.
  - Registered idx 0.
- Reset asserted mid-transaction aborts immediately to these values. Any in-flight upstream response is dropped.
- FSM states: IDLE, ISSUE, WAIT_RSP, RESP.
- IDLE:
  - eligible = req_i & ~done.
  - Winner = first set bit of eligible, searching from the pointer upward with wrap.
  - If eligible is non-zero: register winner idx, go to ISSUE. Otherwise stay.
- ISSUE:
  - up_req_o=1 and up_id_o=idx, held stable until up_ack_i.
  - On the cycle with up_req_o & up_ack_i: gnt_o[idx] pulses, go to WAIT_RSP.
- WAIT_RSP: on up_rsp_valid_i, capture data and eod into registers, go to RESP.
- RESP (one cycle):
  - rsp_valid_o[idx]=1, rsp_data_o and rsp_eod_o driven from the registers.
  - If eod: done[idx] set; it is visible on done_o from the next cycle.
  - Pointer = (idx+1) mod NUM_REQ; return to IDLE.
- Latency: minimum 4 cycles from request sampled to rsp_valid_o (IDLE, ISSUE with immediate ack, WAIT_RSP with immediate response, RESP). Response-to-rsp_valid_o latency is exactly 1 cycle.
- Requests are sampled only in IDLE. Deasserting req_i after the winner is chosen does not cancel; the transaction completes and rsp_valid_o still pulses.
- up_rsp_valid_i is ignored outside WAIT_RSP, including the ack cycle. Upstream responds no earlier than the cycle after ack.
- Drivers with done set are masked from arbitration permanently until reset.
- all_done_o is 1 only when all NUM_REQ bits of done are set. It is combinational from the done register.
- rsp_data_o and rsp_eod_o are 0 when no rsp_valid_o bit is set.
- Pointer wraps from NUM_REQ-1 to 0.
- Fairness: a driver holding req_i continuously waits at most NUM_REQ-1 other transactions.

Optional Feature:
- Macro S2C_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_RSP and increments each cycle in WAIT_RSP.
  - When it reaches TIMEOUT-1 without up_rsp_valid_i, go to RESP with data 0 and eod=1. This sets done[idx] so the top-level end check cannot hang.
  - timeout_err_o is set sticky.
  - up_rsp_valid_i arriving in the same cycle as expiry wins: normal response, no error.
- When undefined: no counter; WAIT_RSP waits indefinitely; timeout_err_o tied 0.

Test Plan:
1. Reset: rst high 25 time units with all inputs 0 → all outputs 0, busy_o=0; after release and req_i=0 for 10 cycles, up_req_o stays 0.
2. Single driver: req_i=4'b0010, ack immediate, response data 0xA5A5_0001 eod=0 one cycle after ack → gnt_o=0010, rsp_valid_o=0010 exactly 4 cycles after req, rsp_data_o=0xA5A5_0001, done_o=0.
3. Round robin: req_i=4'b1111 held, upstream always acks and responds immediately → grant order 0,1,2,3,0, with up_id_o matching each grant.
4. EOD: driver 2 receives eod=1, then drivers 0, 1 and 3 receive eod → done_o=0100 after the first; driver 2 is never granted again; all_done_o rises only after the fourth EOD.
5. Stall and withdraw: req_i=0001 for one cycle, then 0; up_ack_i delayed 5 cycles, response delayed 7 → up_req_o/up_id_o stable for 5 cycles, single gnt_o and rsp_valid_o for driver 0.
6. With S2C_ARB_TIMEOUT_EN and TIMEOUT=16: ack but no response → after 16 cycles in WAIT_RSP, rsp_valid_o pulses with eod=1 and data 0, and timeout_err_o=1 sticky. Assert rst mid-WAIT_RSP → immediate return to IDLE with done_o=0.
